// File: rtl/arbitro_memoria_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// The optional memory-wait timeout is enabled by defining ARB_TIMEOUT_EN.
package arbitro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } arbState_t;

    // Owner encoding doubles as the iord value while the port is granted
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Replicated across DATA_W to form the all-ones read data after a timeout
    localparam logic TIMEOUT_FILL_BIT = 1'b1;

endpackage

// File: rtl/arbitro_memoria_if.sv
// Bundles the requester and memory handshakes of the unified memory port.
// master = arbiter side, slave = requesters plus memory.
interface arbitro_memoria_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              iord;
    logic              stall_if;
    logic              timeout_err;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr,
        output mem_wdata, iord, stall_if, timeout_err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr,
        input  mem_wdata, iord, stall_if, timeout_err
    );

endinterface

// File: rtl/arbitro_memoria_prioridade.sv
// Grant decision between fetch and data requests, with a data-streak counter
// that forces a fetch grant once data has won MAX_DATA_STREAK times in a row.
module arbitro_prioridade
    import arbitro_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic dm_req,
    input  logic arb_en,
    output logic grant_if,
    output logic grant_dm
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak;

    always_comb begin
        grant_dm = arb_en & dm_req & (~if_req | (streak != STREAK_MAX));
        grant_if = arb_en & if_req & ~grant_dm;
    end

    // Only data wins taken while a fetch is waiting count towards starvation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (arb_en) begin
            if (grant_if || !if_req) begin
                streak <= '0;
            end else if (grant_dm && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_memoria.sv
// Serialises IF fetches and MEM data accesses onto one memory handshake.
// Define ARB_TIMEOUT_EN to abandon memory waits after TIMEOUT_CYCLES cycles.
module arbitro_memoria
    import arbitro_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input logic              clk,
    input logic              rst_n,
    arbitro_memoria_if.master bus
);

    arbState_t state;
    logic      owner;
    logic      grantIf;
    logic      grantDm;
    logic      arbEnable;
    logic      waiting;
    logic      timeoutHit;

    assign arbEnable = (state == IDLE);
    assign waiting   = (state == FETCH) || (state == DATA);

    arbitro_prioridade #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) uPrioridade (
        .clk     (clk),
        .rst_n   (rst_n),
        .if_req  (bus.if_req),
        .dm_req  (bus.dm_req),
        .arb_en  (arbEnable),
        .grant_if(grantIf),
        .grant_dm(grantDm)
    );

    assign bus.stall_if = bus.if_req & ~bus.if_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] waitCnt;
    logic              timeoutErr;

    assign timeoutHit      = waiting & ~bus.mem_ack & (waitCnt == WAIT_LAST);
    assign bus.timeout_err = timeoutErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt    <= '0;
            timeoutErr <= 1'b0;
        end else begin
            if (waiting && !bus.mem_ack && !timeoutHit) begin
                waitCnt <= waitCnt + 1'b1;
            end else begin
                waitCnt <= '0;
            end
            if (timeoutHit) begin
                timeoutErr <= 1'b1;
            end
        end
    end
`else
    logic unusedTimeout;

    assign timeoutHit      = 1'b0;
    assign bus.timeout_err = 1'b0;
    assign unusedTimeout   = (TIMEOUT_CYCLES != 0);
`endif

    // Memory-side outputs are registered at grant and held until completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.iord      <= 1'b0;
            bus.if_ready  <= 1'b0;
            bus.dm_ready  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
        end else begin
            bus.if_ready <= 1'b0;
            bus.dm_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grantDm) begin
                        state         <= DATA;
                        owner         <= OWN_DM;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.dm_we;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
                        bus.iord      <= OWN_DM;
                    end else if (grantIf) begin
                        state        <= FETCH;
                        owner        <= OWN_IF;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= bus.if_addr;
                        bus.iord     <= OWN_IF;
                    end
                end
                FETCH, DATA: begin
                    if (bus.mem_ack || timeoutHit) begin
                        state       <= RESP;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        bus.iord    <= 1'b0;
                        if (owner == OWN_DM) begin
                            bus.dm_ready <= 1'b1;
                            if (!bus.mem_ack) begin
                                bus.dm_rdata <= {DATA_W{TIMEOUT_FILL_BIT}};
                            end else if (!bus.mem_we) begin
                                bus.dm_rdata <= bus.mem_rdata;
                            end
                        end else begin
                            bus.if_ready <= 1'b1;
                            bus.if_rdata <= bus.mem_ack ? bus.mem_rdata
                                                        : {DATA_W{TIMEOUT_FILL_BIT}};
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
